// File: rtl/uart_resp_packer.sv
// rtl/uart_resp_packer.sv - serialises a readback response frame into the UART byte transmitter
//
// Purpose:
//   Captures a function code, channel, 32-bit payload and PWM status on a
//   readback request. Sends them as a fixed frame, one byte at a time, using
//   the tx_en / tx_busy handshake of uart_tx.
//   Frame: HEAD0 HEAD1 func ch pay[31:24] pay[23:16] pay[15:8] pay[7:0] status [checksum]
//
// Configuration macro:
//   UART_RESP_CHECKSUM_EN - when defined, appends byte 9. This byte is the
//   8-bit sum of bytes 2..8.
//
// Ports:
//   clk_50M     in   system clock
//   rst_n       in   asynchronous active-low reset
//   rd_req      in   request pulse, sampled only in IDLE
//   rd_func     in   [7:0] function code echoed in the frame
//   rd_ch       in   [7:0] channel number echoed in the frame
//   rd_payload  in   [31:0] readback data
//   pwm_busy    in   [_NUM_CHANNELS-1:0] PWM busy bus
//   pwm_valid   in   [_NUM_CHANNELS-1:0] PWM valid bus
//   tx_busy     in   byte transmitter busy
//   tx_en       out  one-cycle byte start strobe
//   tx_data     out  [7:0] byte to transmit, held until the next tx_en
//   resp_busy   out  frame in progress
//   resp_done   out  one-cycle pulse when the frame completes
//   resp_err    out  one-cycle pulse on transmitter timeout
`timescale 1ns/1ps
module uart_resp_packer #(
  parameter int         _NUM_CHANNELS = 4,
  parameter logic [7:0] _HEAD0        = 8'h55,
  parameter logic [7:0] _HEAD1        = 8'hAA,
  parameter int         _TO_CYCLES    = 1023
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  input  logic                     rd_req,
  input  logic [7:0]               rd_func,
  input  logic [7:0]               rd_ch,
  input  logic [31:0]              rd_payload,
  input  logic [_NUM_CHANNELS-1:0] pwm_busy,
  input  logic [_NUM_CHANNELS-1:0] pwm_valid,
  input  logic                     tx_busy,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  output logic                     resp_busy,
  output logic                     resp_done,
  output logic                     resp_err
);

`ifdef UART_RESP_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif
  localparam logic [15:0] TO_LAST = 16'(_TO_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_func;
  logic [7:0]  r_ch;
  logic [31:0] r_payload;
  logic [7:0]  r_status;
  logic [15:0] r_to_cnt;
  logic        r_tx_en;
  logic [7:0]  r_tx_data;
  logic        r_resp_busy;
  logic        r_resp_done;
  logic        r_resp_err;

  logic [3:0]  w_valid4;
  logic [3:0]  w_busy4;
  logic [3:0]  w_next_idx;
  logic [7:0]  w_next_byte;

  // Zero-extend the PWM buses to 4 bits each for the status byte.
  always_comb begin
    w_valid4 = 4'h0;
    w_busy4  = 4'h0;
    for (int i = 0; i < _NUM_CHANNELS; i++) begin
      w_valid4[i] = pwm_valid[i];
      w_busy4[i]  = pwm_busy[i];
    end
  end

`ifdef UART_RESP_CHECKSUM_EN
  logic [7:0] w_csum;
  assign w_csum = r_func + r_ch + r_payload[31:24] + r_payload[23:16]
                + r_payload[15:8] + r_payload[7:0] + r_status;
`endif

  assign w_next_idx = r_idx + 4'd1;

  // Byte 0 is loaded directly in IDLE. This mux only supplies bytes 1..LAST_IDX.
  always_comb begin
    w_next_byte = 8'h00;
    case (w_next_idx)
      4'd1: w_next_byte = _HEAD1;
      4'd2: w_next_byte = r_func;
      4'd3: w_next_byte = r_ch;
      4'd4: w_next_byte = r_payload[31:24];
      4'd5: w_next_byte = r_payload[23:16];
      4'd6: w_next_byte = r_payload[15:8];
      4'd7: w_next_byte = r_payload[7:0];
      4'd8: w_next_byte = r_status;
`ifdef UART_RESP_CHECKSUM_EN
      4'd9: w_next_byte = w_csum;
`endif
      default: w_next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_func      <= 8'h00;
      r_ch        <= 8'h00;
      r_payload   <= 32'h0;
      r_status    <= 8'h00;
      r_to_cnt    <= 16'h0;
      r_tx_en     <= 1'b0;
      r_tx_data   <= 8'h00;
      r_resp_busy <= 1'b0;
      r_resp_done <= 1'b0;
      r_resp_err  <= 1'b0;
    end else begin
      // Strobes default low, so each one lasts exactly one cycle.
      r_tx_en     <= 1'b0;
      r_resp_done <= 1'b0;
      r_resp_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idx <= 4'd0;
          if (rd_req) begin
            r_func      <= rd_func;
            r_ch        <= rd_ch;
            r_payload   <= rd_payload;
            r_status    <= {w_valid4, w_busy4};
            r_tx_en     <= 1'b1;
            r_tx_data   <= _HEAD0;
            r_resp_busy <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          // tx_en is high during this cycle, which is the first cycle of the timeout window.
          // With a one-cycle budget, the decision has to be made here.
          if (_TO_CYCLES == 1 && !tx_busy) begin
            r_resp_err  <= 1'b1;
            r_resp_busy <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_to_cnt <= 16'd1;
            r_state  <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (tx_busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_to_cnt == TO_LAST) begin
            r_resp_err  <= 1'b1;
            r_resp_busy <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            if (r_idx == LAST_IDX) begin
              r_resp_done <= 1'b1;
              r_resp_busy <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_en   <= 1'b1;
              r_tx_data <= w_next_byte;
              r_state   <= S_SEND;
            end
          end
        end
        S_DONE: begin
          r_idx   <= 4'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_en     = r_tx_en;
  assign tx_data   = r_tx_data;
  assign resp_busy = r_resp_busy;
  assign resp_done = r_resp_done;
  assign resp_err  = r_resp_err;

endmodule

// File: tb/tb_uart_resp_packer.sv
// tb/tb_uart_resp_packer.sv - self-checking bench for uart_resp_packer
`timescale 1ns/1ps
module tb_uart_resp_packer;

`ifdef UART_RESP_CHECKSUM_EN
  localparam int FRAME_LEN = 10;
`else
  localparam int FRAME_LEN = 9;
`endif

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [7:0]  rd_func;
  logic [7:0]  rd_ch;
  logic [31:0] rd_payload;
  logic [3:0]  pwm_busy;
  logic [3:0]  pwm_valid;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        resp_busy;
  logic        resp_done;
  logic        resp_err;

  logic        rd_req2;
  logic [1:0]  pwm_busy2;
  logic [1:0]  pwm_valid2;
  logic        tx_busy2;
  logic        tx_en2;
  logic [7:0]  tx_data2;
  logic        resp_busy2;
  logic        resp_done2;
  logic        resp_err2;

  always #10 clk_50M = ~clk_50M;

  uart_resp_packer #(._NUM_CHANNELS(4), ._TO_CYCLES(16)) u_dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .rd_req(rd_req), .rd_func(rd_func),
    .rd_ch(rd_ch), .rd_payload(rd_payload), .pwm_busy(pwm_busy),
    .pwm_valid(pwm_valid), .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .resp_busy(resp_busy), .resp_done(resp_done), .resp_err(resp_err)
  );

  uart_resp_packer #(._NUM_CHANNELS(2), ._TO_CYCLES(16)) u_dut2 (
    .clk_50M(clk_50M), .rst_n(rst_n), .rd_req(rd_req2), .rd_func(rd_func),
    .rd_ch(rd_ch), .rd_payload(rd_payload), .pwm_busy(pwm_busy2),
    .pwm_valid(pwm_valid2), .tx_busy(tx_busy2), .tx_en(tx_en2), .tx_data(tx_data2),
    .resp_busy(resp_busy2), .resp_done(resp_done2), .resp_err(resp_err2)
  );

  // Transmitter models. Busy goes high the cycle after tx_en and stays high for a fixed time.
  logic       model_en;
  logic [5:0] bcnt;
  logic [5:0] bcnt2;
  always @(posedge clk_50M) begin
    if (tx_en && model_en) bcnt <= 6'd20;
    else if (bcnt != 6'd0) bcnt <= bcnt - 6'd1;
    if (tx_en2) bcnt2 <= 6'd3;
    else if (bcnt2 != 6'd0) bcnt2 <= bcnt2 - 6'd1;
  end
  assign tx_busy  = (bcnt != 6'd0);
  assign tx_busy2 = (bcnt2 != 6'd0);

  typedef struct {
    logic [7:0]  func;
    logic [7:0]  ch;
    logic [31:0] payload;
    logic [3:0]  busy;
    logic [3:0]  valid;
    logic [7:0]  exp_status;
  } vec_t;

  vec_t       vecs[3];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         tx_total = 0;
  int         done_total = 0;
  int         err_total = 0;
  int         tx2_total = 0;
  logic [7:0] status2 = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle, then sample outputs on the falling edge and feed the scoreboard.
  task automatic tick();
    @(negedge clk_50M);
    if (tx_en) begin
      tx_total++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got tx_en with byte %h expected no byte", tx_data);
      end else begin
        chk("sb_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (resp_done) done_total++;
    if (resp_err) err_total++;
    if (resp_done && resp_err) chk("done_err_excl", 32'd1, 32'd0);
    if (tx_en2) begin
      if (tx2_total == 8) status2 = tx_data2;
      tx2_total++;
    end
  endtask

  task automatic push_frame(input vec_t v);
    logic [7:0] b[9];
    logic [7:0] sum;
    b = '{8'h55, 8'hAA, v.func, v.ch, v.payload[31:24], v.payload[23:16],
          v.payload[15:8], v.payload[7:0], v.exp_status};
    sum = 8'h00;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(b[i]);
      if (i >= 2) sum = sum + b[i];
    end
    if (FRAME_LEN == 10) exp_q.push_back(sum);
  endtask

  // Issue a request. On return it is cycle N+1, where tx_en must already be high.
  task automatic send_req(input vec_t v);
    tick();
    rd_func    = v.func;
    rd_ch      = v.ch;
    rd_payload = v.payload;
    pwm_busy   = v.busy;
    pwm_valid  = v.valid;
    rd_req     = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("first_tx_en", {31'h0, tx_en}, 32'd1);
    chk("first_busy", {31'h0, resp_busy}, 32'd1);
  endtask

  task automatic wait_done(input int t0);
    int n = 0;
    while (!resp_done && n < 2000) begin
      tick();
      n++;
    end
    chk("done_seen", {31'h0, resp_done}, 32'd1);
    chk("done_busy_low", {31'h0, resp_busy}, 32'd0);
    chk("frame_len", tx_total - t0, FRAME_LEN);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int t0;
    int n;
    vec_t v;
    vecs[0] = '{8'h81, 8'h01, 32'h12345678, 4'b0010, 4'b0001, 8'h12};
    vecs[1] = '{8'h02, 8'h03, 32'hDEADBEEF, 4'b1111, 4'b0000, 8'h0F};
    vecs[2] = '{8'hFF, 8'hFF, 32'hFFFFFFFF, 4'b1111, 4'b1111, 8'hFF};

    rst_n = 1'b0; rd_req = 1'b0; rd_req2 = 1'b0; model_en = 1'b1;
    rd_func = 8'h00; rd_ch = 8'h00; rd_payload = 32'h0;
    pwm_busy = 4'h0; pwm_valid = 4'h0; pwm_busy2 = 2'b00; pwm_valid2 = 2'b00;
    bcnt = 6'd0; bcnt2 = 6'd0;
    tick(); tick();
    chk("rst_tx_en", {31'h0, tx_en}, 32'd0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h00);
    chk("rst_resp_busy", {31'h0, resp_busy}, 32'd0);
    chk("rst_resp_done", {31'h0, resp_done}, 32'd0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Checksum for vector 0 is known: 12 A8 at the end of the frame.
    if (FRAME_LEN == 10) chk("v0_checksum_model", 32'h0, 32'h0 + ((8'h81 + 8'h01 + 8'h12 + 8'h34 + 8'h56 + 8'h78 + 8'h12) & 8'hFF) - 32'hA8);

    // Table-driven frames, issued back-to-back at cycle M+2 after each done.
    for (int i = 0; i < 3; i++) begin
      t0 = tx_total;
      push_frame(vecs[i]);
      send_req(vecs[i]);
      wait_done(t0);
    end

    // A second request in mid-frame must be ignored.
    t0 = tx_total;
    push_frame(vecs[0]);
    send_req(vecs[0]);
    for (int k = 0; k < 50; k++) tick();
    rd_func = 8'h02; rd_ch = 8'h77; rd_payload = 32'h0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wait_done(t0);

    // Timeout: the transmitter never raises busy.
    model_en = 1'b0;
    t0 = tx_total;
    n = done_total;
    exp_q.push_back(8'h55);
    send_req(vecs[1]);
    begin
      int c = 0;
      while (!resp_err && c < 100) begin
        tick();
        c++;
      end
      chk("timeout_cycles", c, 16);
    end
    chk("timeout_busy_low", {31'h0, resp_busy}, 32'd0);
    chk("timeout_one_tx", tx_total - t0, 1);
    chk("timeout_no_done", done_total - n, 0);
    tick();
    chk("timeout_err_pulse", {31'h0, resp_err}, 32'd0);
    model_en = 1'b1;
    t0 = tx_total;
    push_frame(vecs[2]);
    send_req(vecs[2]);
    wait_done(t0);

    // Reset during byte 5.
    t0 = tx_total;
    push_frame(vecs[1]);
    send_req(vecs[1]);
    n = 0;
    while (tx_total - t0 < 6 && n < 2000) begin
      tick();
      n++;
    end
    chk("reach_byte5", tx_total - t0, 6);
    rst_n = 1'b0;
    tick();
    chk("mrst_tx_en", {31'h0, tx_en}, 32'd0);
    chk("mrst_tx_data", {24'h0, tx_data}, 32'h00);
    chk("mrst_resp_busy", {31'h0, resp_busy}, 32'd0);
    chk("mrst_resp_done", {31'h0, resp_done}, 32'd0);
    chk("mrst_resp_err", {31'h0, resp_err}, 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    t0 = tx_total;
    push_frame(vecs[0]);
    send_req(vecs[0]);
    wait_done(t0);

    // Two-channel instance: the status byte zero-extends each bus.
    tick();
    pwm_busy2 = 2'b11; pwm_valid2 = 2'b10; rd_req2 = 1'b1;
    tick();
    rd_req2 = 1'b0;
    n = 0;
    while (tx2_total < 9 && n < 2000) begin
      tick();
      n++;
    end
    chk("ch2_bytes", tx2_total, 9);
    chk("ch2_status", {24'h0, status2}, 32'h23);
    chk("ch2_no_err", {31'h0, resp_err2}, 32'd0);
    chk("total_errs", err_total, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
